hand_tracker: RTL and testbench

- Per-frame centroid tracker for the two coloured hand markers.
- Consumes the classified pixel stream (hcount/vcount/blank plus per-pixel hand1/hand2 flags from the colour thresholder) and produces userhand1x/y, userhand2x/y, usergrab1/2.
- These outputs feed the movement stage through the packed info bus.
- A grab is inferred from marker pixel area (fist closed shows more marker) with hysteresis and debounce.

---
 rtl/hand_tracker.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_hand_tracker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hand_tracker.sv
// hand_tracker: per-frame centroid tracker for two coloured hand markers.
// Accumulates x/y sums and pixel counts of hand-1/hand-2 marker pixels over
// the active area. On each vsync falling edge it divides sum by count with one
// shared restoring divider and commits both centroids and the debounced grab
// flags together, pulsing update for one cycle.
//
// Ports:
//   clock_65mhz, reset_n           pixel clock, async active-low reset
//   hcount, vcount, vsync, blank   raster timing (vsync active-low)
//   is_hand1, is_hand2             per-pixel marker classification
//   userhand{1,2}{x,y}             committed centroids (reset 512/384)
//   usergrab1, usergrab2           debounced grab state
//   update                         one-cycle pulse when the outputs commit
//
// Optional build macro: HAND_SMOOTH_EN -- commit (old + new + 1) >> 1 instead
// of the raw centroid for hands that were found this frame.
module hand_tracker #(
  parameter int unsigned H_ACTIVE   = 1024,
  parameter int unsigned V_ACTIVE   = 768,
  parameter int unsigned MIN_PIXELS = 64,
  parameter int unsigned GRAB_ON    = 2000,
  parameter int unsigned GRAB_OFF   = 1200,
  parameter int unsigned DEBOUNCE   = 3
) (
  input  logic        clock_65mhz,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        vsync,
  input  logic        blank,
  input  logic        is_hand1,
  input  logic        is_hand2,
  output logic [10:0] userhand1x,
  output logic [9:0]  userhand1y,
  output logic [10:0] userhand2x,
  output logic [9:0]  userhand2y,
  output logic        usergrab1,
  output logic        usergrab2,
  output logic        update
);

  localparam int unsigned XW    = 11;
  localparam int unsigned YW    = 10;
  localparam int unsigned SXW   = 31;
  localparam int unsigned SYW   = 30;
  localparam int unsigned CW    = 20;
  localparam int unsigned ITW   = 5;
  localparam int unsigned NITER = 31;
  localparam int unsigned DCW   = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

  localparam logic [CW-1:0]  MIN_C      = CW'(MIN_PIXELS);
  localparam logic [CW-1:0]  GRAB_ON_C  = CW'(GRAB_ON);
  localparam logic [CW-1:0]  GRAB_OFF_C = CW'(GRAB_OFF);
  localparam logic [XW-1:0]  X_MAX      = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]  Y_MAX      = YW'(V_ACTIVE - 1);
  localparam logic [XW-1:0]  X_RST      = XW'(H_ACTIVE / 2);
  localparam logic [YW-1:0]  Y_RST      = YW'(V_ACTIVE / 2);
  localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV_X1,
    ST_DIV_Y1,
    ST_DIV_X2,
    ST_DIV_Y2,
    ST_COMMIT
  } state_e;

  // Frame-edge detection and pixel qualification
  logic       vsync_q;
  logic       frame_end_c;
  logic [1:0] hit_c;

  // Running accumulators and per-frame snapshots, indexed by hand
  logic [SXW-1:0] sumx_q [2];
  logic [SXW-1:0] sumx_d [2];
  logic [SYW-1:0] sumy_q [2];
  logic [SYW-1:0] sumy_d [2];
  logic [CW-1:0]  cnt_q  [2];
  logic [CW-1:0]  cnt_d  [2];
  logic [SXW-1:0] snap_sx_q  [2];
  logic [SXW-1:0] snap_sx_d  [2];
  logic [SYW-1:0] snap_sy_q  [2];
  logic [SYW-1:0] snap_sy_d  [2];
  logic [CW-1:0]  snap_cnt_q [2];
  logic [CW-1:0]  snap_cnt_d [2];

  // Sequencer and shared divider
  state_e         state_q, state_d;
  logic [ITW-1:0] iter_q, iter_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic [SXW-1:0] quo_q, quo_d;

  // Division results waiting for commit
  logic [XW-1:0] resx_q [2];
  logic [XW-1:0] resx_d [2];
  logic [YW-1:0] resy_q [2];
  logic [YW-1:0] resy_d [2];

  // Committed outputs and debounce state
  logic [XW-1:0]  posx_q [2];
  logic [XW-1:0]  posx_d [2];
  logic [YW-1:0]  posy_q [2];
  logic [YW-1:0]  posy_d [2];
  logic [1:0]     grab_q, grab_d;
  logic [DCW-1:0] deb_q [2];
  logic [DCW-1:0] deb_d [2];
  logic           update_q, update_d;

  // Divider decode
  logic           div_h_c;
  logic           div_y_c;
  logic [SXW-1:0] dividend_c;
  logic [CW-1:0]  divisor_c;
  logic [CW:0]    rem_sh_c;
  logic           div_ge_c;
  logic [CW-1:0]  rem_nx_c;
  logic [SXW-1:0] quo_nx_c;
  logic [XW-1:0]  x_clip_c;
  logic [YW-1:0]  y_clip_c;
  logic [1:0]     lost_c;
  logic [1:0]     qual_c;
  state_e         next_div_c;

`ifdef HAND_SMOOTH_EN
  // One-pole smoothing with a one-bit-wider intermediate so the sum never wraps
  function automatic logic [XW-1:0] smooth_x(input logic [XW-1:0] a, input logic [XW-1:0] b);
    logic [XW:0] s;
    s = {1'b0, a} + {1'b0, b} + (XW+1)'(1);
    return s[XW:1];
  endfunction

  function automatic logic [YW-1:0] smooth_y(input logic [YW-1:0] a, input logic [YW-1:0] b);
    logic [YW:0] s;
    s = {1'b0, a} + {1'b0, b} + (YW+1)'(1);
    return s[YW:1];
  endfunction
`endif

  assign frame_end_c = vsync_q & ~vsync;
  assign hit_c       = {is_hand2, is_hand1} & {2{~blank}};

  // Shared restoring divider step and per-hand frame classification
  always_comb begin
    div_h_c    = (state_q == ST_DIV_X2) || (state_q == ST_DIV_Y2);
    div_y_c    = (state_q == ST_DIV_Y1) || (state_q == ST_DIV_Y2);
    dividend_c = div_y_c ? SXW'(snap_sy_q[div_h_c]) : snap_sx_q[div_h_c];
    divisor_c  = snap_cnt_q[div_h_c];
    rem_sh_c   = {rem_q, quo_q[SXW-1]};
    div_ge_c   = (rem_sh_c >= {1'b0, divisor_c});
    // remainder stays below the divisor, so the top bit is always zero here
    rem_nx_c   = div_ge_c ? CW'(rem_sh_c - {1'b0, divisor_c}) : CW'(rem_sh_c);
    quo_nx_c   = {quo_q[SXW-2:0], div_ge_c};
    x_clip_c   = (quo_nx_c > SXW'(X_MAX)) ? X_MAX : quo_nx_c[XW-1:0];
    y_clip_c   = (quo_nx_c > SXW'(Y_MAX)) ? Y_MAX : quo_nx_c[YW-1:0];
    lost_c     = '0;
    qual_c     = '0;
    for (int h = 0; h < 2; h++) begin
      lost_c[h] = (snap_cnt_q[h] < MIN_C);
      // grabbing hands look for open frames (a lost hand counts as open),
      // released hands look for closed frames
      qual_c[h] = grab_q[h] ? (lost_c[h] || (snap_cnt_q[h] < GRAB_OFF_C))
                            : (snap_cnt_q[h] >= GRAB_ON_C);
    end
    unique case (state_q)
      ST_DIV_X1: next_div_c = ST_DIV_Y1;
      ST_DIV_Y1: next_div_c = ST_DIV_X2;
      ST_DIV_X2: next_div_c = ST_DIV_Y2;
      default:   next_div_c = ST_COMMIT;
    endcase
  end

  // Next-state: accumulation, snapshot, division sequencing and commit
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    sumx_d     = sumx_q;
    sumy_d     = sumy_q;
    cnt_d      = cnt_q;
    snap_sx_d  = snap_sx_q;
    snap_sy_d  = snap_sy_q;
    snap_cnt_d = snap_cnt_q;
    resx_d     = resx_q;
    resy_d     = resy_q;
    posx_d     = posx_q;
    posy_d     = posy_q;
    grab_d     = grab_q;
    deb_d      = deb_q;
    update_d   = 1'b0;

    for (int h = 0; h < 2; h++) begin
      if (frame_end_c) begin
        // a pixel on the edge cycle starts the new frame
        sumx_d[h] = hit_c[h] ? SXW'(hcount) : '0;
        sumy_d[h] = hit_c[h] ? SYW'(vcount) : '0;
        cnt_d[h]  = hit_c[h] ? CW'(1) : '0;
        // a busy sequencer keeps its snapshot, so this frame is dropped
        if (state_q == ST_IDLE) begin
          snap_sx_d[h]  = sumx_q[h];
          snap_sy_d[h]  = sumy_q[h];
          snap_cnt_d[h] = cnt_q[h];
        end
      end else if (hit_c[h]) begin
        sumx_d[h] = sumx_q[h] + SXW'(hcount);
        sumy_d[h] = sumy_q[h] + SYW'(vcount);
        cnt_d[h]  = cnt_q[h] + CW'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        iter_d = '0;
        if (frame_end_c) state_d = ST_DIV_X1;
      end
      ST_DIV_X1, ST_DIV_Y1, ST_DIV_X2, ST_DIV_Y2: begin
        if (lost_c[div_h_c]) begin
          // lost hand: nothing to divide, the commit keeps the held value
          state_d = next_div_c;
        end else if (iter_q == '0) begin
          rem_d  = '0;
          quo_d  = dividend_c;
          iter_d = ITW'(1);
        end else begin
          rem_d = rem_nx_c;
          quo_d = quo_nx_c;
          if (iter_q == ITW'(NITER)) begin
            if (div_y_c) resy_d[div_h_c] = y_clip_c;
            else         resx_d[div_h_c] = x_clip_c;
            iter_d  = '0;
            state_d = next_div_c;
          end else begin
            iter_d = iter_q + ITW'(1);
          end
        end
      end
      ST_COMMIT: begin
        update_d = 1'b1;
        state_d  = ST_IDLE;
        for (int h = 0; h < 2; h++) begin
          if (!lost_c[h]) begin
`ifdef HAND_SMOOTH_EN
            posx_d[h] = smooth_x(posx_q[h], resx_q[h]);
            posy_d[h] = smooth_y(posy_q[h], resy_q[h]);
`else
            posx_d[h] = resx_q[h];
            posy_d[h] = resy_q[h];
`endif
          end
          if (qual_c[h]) begin
            if (deb_q[h] == DEB_LAST) begin
              grab_d[h] = ~grab_q[h];
              deb_d[h]  = '0;
            end else begin
              deb_d[h] = deb_q[h] + DCW'(1);
            end
          end else begin
            deb_d[h] = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q  <= 1'b0;
      state_q  <= ST_IDLE;
      iter_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      grab_q   <= '0;
      update_q <= 1'b0;
      for (int h = 0; h < 2; h++) begin
        sumx_q[h]     <= '0;
        sumy_q[h]     <= '0;
        cnt_q[h]      <= '0;
        snap_sx_q[h]  <= '0;
        snap_sy_q[h]  <= '0;
        snap_cnt_q[h] <= '0;
        resx_q[h]     <= X_RST;
        resy_q[h]     <= Y_RST;
        posx_q[h]     <= X_RST;
        posy_q[h]     <= Y_RST;
        deb_q[h]      <= '0;
      end
    end else begin
      vsync_q  <= vsync;
      state_q  <= state_d;
      iter_q   <= iter_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      grab_q   <= grab_d;
      update_q <= update_d;
      for (int h = 0; h < 2; h++) begin
        sumx_q[h]     <= sumx_d[h];
        sumy_q[h]     <= sumy_d[h];
        cnt_q[h]      <= cnt_d[h];
        snap_sx_q[h]  <= snap_sx_d[h];
        snap_sy_q[h]  <= snap_sy_d[h];
        snap_cnt_q[h] <= snap_cnt_d[h];
        resx_q[h]     <= resx_d[h];
        resy_q[h]     <= resy_d[h];
        posx_q[h]     <= posx_d[h];
        posy_q[h]     <= posy_d[h];
        deb_q[h]      <= deb_d[h];
      end
    end
  end

  assign userhand1x = posx_q[0];
  assign userhand1y = posy_q[0];
  assign userhand2x = posx_q[1];
  assign userhand2y = posy_q[1];
  assign usergrab1  = grab_q[0];
  assign usergrab2  = grab_q[1];
  assign update     = update_q;

endmodule

// File: tb/tb_hand_tracker.sv
// tb_hand_tracker: randomized pixel streams checked against a frame-level
// model (sums, counts, integer centroid, grab debounce counters).
module tb_hand_tracker;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [10:0] hcount   = '0;
  logic [9:0]  vcount   = '0;
  logic        vsync    = 1'b1;
  logic        blank    = 1'b1;
  logic        is_hand1 = 1'b0;
  logic        is_hand2 = 1'b0;
  logic [10:0] h1x, h2x;
  logic [9:0]  h1y, h2y;
  logic        g1, g2, upd;

  hand_tracker dut (
    .clock_65mhz (clk),
    .reset_n     (rst_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .vsync       (vsync),
    .blank       (blank),
    .is_hand1    (is_hand1),
    .is_hand2    (is_hand2),
    .userhand1x  (h1x),
    .userhand1y  (h1y),
    .userhand2x  (h2x),
    .userhand2y  (h2y),
    .usergrab1   (g1),
    .usergrab2   (g2),
    .update      (upd)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Frame-level model state
  int m_sx[2], m_sy[2], m_cnt[2];
  int m_x[2], m_y[2], m_g[2], m_c[2];
  int bx[2], by[2], bw[2], bh[2];

  int          bad_change = 0;
  logic [43:0] prev_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs may only move on the cycle that update is high
  always @(negedge clk) begin
    if (rst_n && !upd && ({h1x, h1y, h2x, h2y, g1, g2} != prev_out)) bad_change++;
    prev_out = {h1x, h1y, h2x, h2y, g1, g2};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int h = 0; h < 2; h++) begin
      m_sx[h] = 0; m_sy[h] = 0; m_cnt[h] = 0;
      m_x[h] = 512; m_y[h] = 384; m_g[h] = 0; m_c[h] = 0;
    end
  endtask

  task automatic drive(input int x, input int y, input bit blk, input bit f1, input bit f2);
    hcount   = 11'(x);
    vcount   = 10'(y);
    blank    = blk;
    is_hand1 = f1;
    is_hand2 = f2;
  endtask

  task automatic put_hand(input int h);
    int x, y;
    x = bx[h] + int'($urandom_range(0, bw[h] - 1));
    y = by[h] + int'($urandom_range(0, bh[h] - 1));
    drive(x, y, 1'b0, h == 0, h == 1);
    m_sx[h] += x; m_sy[h] += y; m_cnt[h]++;
  endtask

  // Interleave hand-1, hand-2, plain active and blanked-with-flags pixels
  task automatic stream(input int n1, input int n2, input int nn, input int nb);
    int r[4];
    r[0] = n1; r[1] = n2; r[2] = nn; r[3] = nb;
    while (r[0] + r[1] + r[2] + r[3] > 0) begin
      int k;
      do k = int'($urandom_range(0, 3)); while (r[k] == 0);
      r[k]--;
      @(negedge clk);
      vsync = 1'b1;
      case (k)
        0, 1: put_hand(k);
        2: drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 767)), 1'b0, 1'b0, 1'b0);
        default: drive(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'b1,
                       1'b1, $urandom_range(0, 1) == 1);
      endcase
    end
  endtask

  task automatic square1();
    for (int y = 200; y < 210; y++)
      for (int x = 100; x < 110; x++) begin
        @(negedge clk);
        vsync = 1'b1;
        drive(x, y, 1'b0, 1'b1, 1'b0);
        m_sx[0] += x; m_sy[0] += y; m_cnt[0]++;
      end
  endtask

  // Drop vsync, predict the commit, and check the committed values
  task automatic end_frame(input string nm, input bit edge_px);
    int s_sx[2], s_sy[2], s_cnt[2];
    int exp_lat, lat, ey, nx, ny;
    bit lost, qual;
    @(negedge clk);
    vsync = 1'b0;
    ey = int'($urandom_range(0, 767));
    if (edge_px) drive(1023, ey, 1'b0, 1'b1, 1'b0);
    else         drive(0, 0, 1'b1, 1'b0, 1'b0);
    exp_lat = 1;
    for (int h = 0; h < 2; h++) begin
      s_sx[h] = m_sx[h]; s_sy[h] = m_sy[h]; s_cnt[h] = m_cnt[h];
      m_sx[h] = 0; m_sy[h] = 0; m_cnt[h] = 0;
      lost = s_cnt[h] < 64;
      exp_lat += lost ? 2 : 64;
      if (!lost) begin
        nx = s_sx[h] / s_cnt[h]; if (nx > 1023) nx = 1023;
        ny = s_sy[h] / s_cnt[h]; if (ny > 767)  ny = 767;
`ifdef HAND_SMOOTH_EN
        m_x[h] = (m_x[h] + nx + 1) / 2;
        m_y[h] = (m_y[h] + ny + 1) / 2;
`else
        m_x[h] = nx;
        m_y[h] = ny;
`endif
      end
      qual = (m_g[h] != 0) ? (lost || s_cnt[h] < 1200) : (s_cnt[h] >= 2000);
      if (qual) begin
        m_c[h]++;
        if (m_c[h] == 3) begin m_g[h] = 1 - m_g[h]; m_c[h] = 0; end
      end else begin
        m_c[h] = 0;
      end
    end
    if (edge_px) begin m_sx[0] = 1023; m_sy[0] = ey; m_cnt[0] = 1; end
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (upd) begin lat = k - 1; break; end
      drive(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'b1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_h1x"}, 32'(h1x), 32'(m_x[0]));
    check({nm, "_h1y"}, 32'(h1y), 32'(m_y[0]));
    check({nm, "_h2x"}, 32'(h2x), 32'(m_x[1]));
    check({nm, "_h2y"}, 32'(h2y), 32'(m_y[1]));
    check({nm, "_grab1"}, 32'(g1), 32'(m_g[0]));
    check({nm, "_grab2"}, 32'(g2), 32'(m_g[1]));
    @(negedge clk);
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    check({nm, "_update_width"}, 32'(upd), 32'd0);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_h1x"}, 32'(h1x), 32'd512);
    check({nm, "_h1y"}, 32'(h1y), 32'd384);
    check({nm, "_h2x"}, 32'(h2x), 32'd512);
    check({nm, "_h2y"}, 32'(h2y), 32'd384);
    check({nm, "_grab1"}, 32'(g1), 32'd0);
    check({nm, "_grab2"}, 32'(g2), 32'd0);
    check({nm, "_update"}, 32'(upd), 32'd0);
  endtask

  initial begin
    int g2seq[11];
    g2seq = '{2500, 2500, 1500, 2500, 2500, 2500, 1500, 1500, 40, 40, 40};
    model_reset();
    for (int h = 0; h < 2; h++) begin
      bx[h] = 300 + 200 * h; by[h] = 100 + 100 * h; bw[h] = 120; bh[h] = 90;
    end
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;

    // Exact 10x10 square on hand 1; hand 2 absent holds its reset position
    stream(0, 0, 20, 30);
    square1();
    stream(0, 0, 10, 20);
    end_frame("square", 1'b0);

    // Reset while marker pixels are streaming, then a frame from scratch
    stream(400, 300, 40, 40);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    model_reset();
    stream(150, 120, 30, 30);
    end_frame("fresh", 1'b1);

    // Frame that includes the edge pixel from the previous frame end
    stream(200, 90, 20, 20);
    end_frame("edge", 1'b0);

    // Hand-2 grab debounce: neutral break, engage, neutral hold, lost release
    for (int i = 0; i < 11; i++) begin
      bx[1] = int'($urandom_range(0, 900)); by[1] = int'($urandom_range(0, 660));
      bw[1] = 100; bh[1] = 100;
      stream(int'($urandom_range(0, 300)), g2seq[i], 10, 10);
      end_frame($sformatf("grab%0d", i), $urandom_range(0, 1) == 1);
    end

    // Centroid beyond the active area clips to 1023/767
    bx[0] = 1500; by[0] = 900; bw[0] = 100; bh[0] = 100;
    stream(120, 0, 10, 10);
    end_frame("clip", 1'b0);

    check("no_spurious_change", 32'(bad_change), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
